// File: rtl/axi_hp_pkg.sv
// Shared constants and FSM state encodings for the HP-port memory responder.
// Both FSMs are exported on debug ports so checkers can bind to them.
package axi_hp_pkg;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_8B     = 3'b011;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_DATA = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// A read and a write to the same word in one cycle returns the old contents.
module sdp_ram #(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [63:0]          wdata,
   input  logic [7:0]           wstrb,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [63:0]          rdata
);

   logic [63:0] mem [0:(1<<ADDR_BITS)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 8; b++) begin
            if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Read port holds its value while re is low, which keeps RDATA stable under backpressure.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_hp_mem_responder.sv
// AXI3 slave standing in for the Zynq HP-port DDR path, backed by on-chip RAM.
// Handshake rule on every channel: a beat transfers on a rising edge where VALID && READY.
module axi_hp_mem_responder
   import axi_hp_pkg::*;
#(
   parameter int ADDR_BITS = 10,
   parameter int RD_LAT    = 2
) (
   input  logic        fclk,
   input  logic        rst_n,
   input  logic [31:0] S_AXI_ARADDR,
   input  logic [3:0]  S_AXI_ARLEN,
   input  logic [2:0]  S_AXI_ARSIZE,
   input  logic [1:0]  S_AXI_ARBURST,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   output logic [63:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RLAST,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY,
   input  logic [31:0] S_AXI_AWADDR,
   input  logic [3:0]  S_AXI_AWLEN,
   input  logic [2:0]  S_AXI_AWSIZE,
   input  logic [1:0]  S_AXI_AWBURST,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [63:0] S_AXI_WDATA,
   input  logic [7:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WLAST,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   input  logic        rd_stall,
   input  logic        wr_stall,
   output logic [1:0]  rd_fsm,
   output logic [1:0]  wr_fsm
);

   localparam logic [7:0] RD_WAIT_INIT = (RD_LAT > 1) ? 8'(RD_LAT - 2) : 8'd0;

   logic [ADDR_BITS-1:0] ar_idx, aw_idx;
   logic                 ar_ok, aw_ok;

   assign ar_idx = S_AXI_ARADDR[ADDR_BITS+2:3];
   assign aw_idx = S_AXI_AWADDR[ADDR_BITS+2:3];
   assign ar_ok  = (S_AXI_ARSIZE == SIZE_8B) && (S_AXI_ARBURST == BURST_INCR);
   assign aw_ok  = (S_AXI_AWSIZE == SIZE_8B) && (S_AXI_AWBURST == BURST_INCR);

   wire unused_addr = ^{S_AXI_ARADDR[31:ADDR_BITS+3], S_AXI_ARADDR[2:0],
                        S_AXI_AWADDR[31:ADDR_BITS+3], S_AXI_AWADDR[2:0]};

   // ---------------- read channel ----------------
   rd_state_t            rd_state;
   logic [ADDR_BITS-1:0] rd_idx, raddr;
   logic [3:0]           rd_left;
   logic [7:0]           rd_wait;
   logic                 rd_err, rvalid_q, arready_q, rd_issue;
   logic                 ar_hs, r_hs;
   logic [63:0]          ram_q;

   assign ar_hs = arready_q & S_AXI_ARVALID;
   assign r_hs  = rvalid_q & S_AXI_RREADY;

   // A RAM read is issued one cycle before each beat is presented; rd_idx is the next word to fetch.
   always_comb begin
      rd_issue = 1'b0;
      raddr    = rd_idx;
      case (rd_state)
         R_IDLE: begin
            raddr    = ar_idx;
            rd_issue = ar_hs && (RD_LAT == 1);
         end
         R_WAIT:  rd_issue = (rd_wait == 8'd0);
         R_DATA:  rd_issue = r_hs && (rd_left != 4'd0);
         default: rd_issue = 1'b0;
      endcase
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rd_idx    <= '0;
         rd_left   <= 4'd0;
         rd_wait   <= 8'd0;
         rd_err    <= 1'b0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               arready_q <= !ar_hs;
               if (ar_hs) begin
                  rd_left <= S_AXI_ARLEN;
                  rd_err  <= !ar_ok;
                  rd_wait <= RD_WAIT_INIT;
                  if (RD_LAT == 1) begin
                     rd_state <= R_DATA;
                     rvalid_q <= !rd_stall;
                     rd_idx   <= ar_idx + 1'b1;
                  end else begin
                     rd_state <= R_WAIT;
                     rd_idx   <= ar_idx;
                  end
               end
            end
            R_WAIT: begin
               if (rd_wait == 8'd0) begin
                  rd_state <= R_DATA;
                  rvalid_q <= !rd_stall;
                  rd_idx   <= rd_idx + 1'b1;
               end else begin
                  rd_wait <= rd_wait - 8'd1;
               end
            end
            R_DATA: begin
               // rd_stall only gates the next beat; a presented beat stays up until taken.
               if (!rvalid_q) begin
                  rvalid_q <= !rd_stall;
               end else if (r_hs) begin
                  if (rd_left == 4'd0) begin
                     rvalid_q  <= 1'b0;
                     rd_state  <= R_IDLE;
                     arready_q <= 1'b1;
                  end else begin
                     rvalid_q <= !rd_stall;
                     rd_left  <= rd_left - 4'd1;
                     rd_idx   <= rd_idx + 1'b1;
                  end
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RLAST   = rvalid_q && (rd_left == 4'd0);
   assign S_AXI_RRESP   = (rvalid_q && rd_err) ? RESP_SLVERR : RESP_OKAY;
   assign S_AXI_RDATA   = rvalid_q ? ram_q : 64'd0;
   assign rd_fsm        = rd_state;

   // ---------------- write channel ----------------
   wr_state_t            wr_state;
   logic [ADDR_BITS-1:0] wr_idx;
   logic [3:0]           wr_exp;
   logic [4:0]           wr_cnt;
   logic                 wr_err, awready_q, aw_hs, w_hs;

   assign aw_hs = awready_q & S_AXI_AWVALID;
   assign w_hs  = (wr_state == W_DATA) && !wr_stall && S_AXI_WVALID;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state  <= W_IDLE;
         awready_q <= 1'b0;
         wr_idx    <= '0;
         wr_exp    <= 4'd0;
         wr_cnt    <= 5'd0;
         wr_err    <= 1'b0;
      end else begin
         case (wr_state)
            W_IDLE: begin
               awready_q <= !aw_hs;
               if (aw_hs) begin
                  wr_state <= W_DATA;
                  wr_idx   <= aw_idx;
                  wr_exp   <= S_AXI_AWLEN;
                  wr_cnt   <= 5'd0;
                  wr_err   <= !aw_ok;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  wr_idx <= wr_idx + 1'b1;
                  // Saturates at 16 so overlong bursts still compare unequal at WLAST.
                  if (wr_cnt != 5'd16) wr_cnt <= wr_cnt + 5'd1;
                  if (S_AXI_WLAST) begin
                     wr_state <= W_RESP;
                     if (wr_cnt != {1'b0, wr_exp}) wr_err <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  wr_state  <= W_IDLE;
                  awready_q <= 1'b1;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = (wr_state == W_DATA) && !wr_stall;
   assign S_AXI_BVALID  = (wr_state == W_RESP);
   assign S_AXI_BRESP   = ((wr_state == W_RESP) && wr_err) ? RESP_SLVERR : RESP_OKAY;
   assign wr_fsm        = wr_state;

   sdp_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
      .clk   (fclk),
      .we    (w_hs),
      .waddr (wr_idx),
      .wdata (S_AXI_WDATA),
      .wstrb (S_AXI_WSTRB),
      .re    (rd_issue),
      .raddr (raddr),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_axi_hp_mem_responder.sv
// Directed bench for axi_hp_mem_responder: burst writes/reads, errors, strobes,
// index wrap, concurrency, backpressure and mid-burst reset.
module tb_axi_hp_mem_responder;

   localparam int BUDGET = 400;

   logic        fclk = 1'b0;
   logic        rst_n;
   logic [31:0] S_AXI_ARADDR;
   logic [3:0]  S_AXI_ARLEN;
   logic [2:0]  S_AXI_ARSIZE;
   logic [1:0]  S_AXI_ARBURST;
   logic        S_AXI_ARVALID, S_AXI_ARREADY;
   logic [63:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
   logic [31:0] S_AXI_AWADDR;
   logic [3:0]  S_AXI_AWLEN;
   logic [2:0]  S_AXI_AWSIZE;
   logic [1:0]  S_AXI_AWBURST;
   logic        S_AXI_AWVALID, S_AXI_AWREADY;
   logic [63:0] S_AXI_WDATA;
   logic [7:0]  S_AXI_WSTRB;
   logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID, S_AXI_BREADY;
   logic        rd_stall, wr_stall;
   logic [1:0]  rd_fsm, wr_fsm;

   axi_hp_mem_responder #(.ADDR_BITS(10), .RD_LAT(2)) dut (
      .fclk(fclk), .rst_n(rst_n),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
      .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
      .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .rd_stall(rd_stall), .wr_stall(wr_stall), .rd_fsm(rd_fsm), .wr_fsm(wr_fsm)
   );

   // ---------------- clock / reset ----------------
   always #5 fclk = ~fclk;

   // ---------------- scoreboard state ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic [63:0] wd [0:31];

   logic [1:0]  wr_bresp;
   bit          wr_timeout, wr_bvalid_next, wr_awready_after;

   logic [63:0] rd_data [0:31];
   logic [1:0]  rd_resp [0:31];
   bit          rd_lastv [0:31];
   int          rd_n, rd_lat, rd_unstable, rd_last_cnt;
   logic [1:0]  rd_resp_or;
   bit          rd_timeout, rd_ar_drop, rd_ar_after, rd_aborted;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Compares the captured read beats against start, start+1, ...
   task automatic expect_seq(input string tag, input logic [63:0] start, input int cnt);
      for (int i = 0; i < cnt; i++) exp_q.push_back(start + 64'(i));
      for (int i = 0; i < cnt; i++) check(tag, rd_data[i], exp_q.pop_front());
   endtask

   // ---------------- driver tasks ----------------
   task automatic wr_burst(input logic [31:0] addr, input logic [3:0] len, input int nb,
                           input logic [7:0] strb, input bit stall_mode);
      int cyc;
      bit hs;
      wr_timeout = 0;
      cyc = 0;
      S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWSIZE = 3'b011; S_AXI_AWBURST = 2'b01;
      S_AXI_AWVALID = 1'b1;
      do begin
         hs = S_AXI_AWREADY;
         @(posedge fclk); #1; cyc++;
      end while (!hs && cyc < BUDGET);
      S_AXI_AWVALID = 1'b0;
      if (!hs) wr_timeout = 1;
      for (int i = 0; i < nb && !wr_timeout; i++) begin
         S_AXI_WDATA = wd[i]; S_AXI_WSTRB = strb; S_AXI_WLAST = (i == nb - 1);
         S_AXI_WVALID = 1'b1;
         do begin
            wr_stall = stall_mode && ((cyc % 3) == 1);
            #1;
            hs = S_AXI_WREADY;
            @(posedge fclk); #1; cyc++;
         end while (!hs && cyc < BUDGET);
         if (!hs) wr_timeout = 1;
      end
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; wr_stall = 1'b0;
      wr_bvalid_next = S_AXI_BVALID;
      S_AXI_BREADY = 1'b1;
      do begin
         hs = S_AXI_BVALID;
         wr_bresp = S_AXI_BRESP;
         @(posedge fclk); #1; cyc++;
      end while (!hs && cyc < BUDGET);
      if (!hs) wr_timeout = 1;
      S_AXI_BREADY = 1'b0;
      wr_awready_after = S_AXI_AWREADY;
   endtask

   task automatic rd_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input bit mode, input int abort_after);
      int cyc, lat;
      bit hs, seen, prev_hold, done, rr;
      logic [63:0] p_data;
      logic [1:0]  p_resp;
      logic        p_last;
      for (int i = 0; i < 32; i++) begin
         rd_data[i] = 64'hDEAD_DEAD_DEAD_DEAD; rd_resp[i] = 2'b11; rd_lastv[i] = 0;
      end
      rd_n = 0; rd_lat = -1; rd_unstable = 0; rd_last_cnt = 0; rd_resp_or = 2'b00;
      rd_timeout = 0; rd_aborted = 0;
      cyc = 0; lat = 1; seen = 0; prev_hold = 0; done = 0;
      p_data = '0; p_resp = '0; p_last = 0;
      S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARSIZE = size; S_AXI_ARBURST = 2'b01;
      S_AXI_ARVALID = 1'b1;
      do begin
         hs = S_AXI_ARREADY;
         @(posedge fclk); #1; cyc++;
      end while (!hs && cyc < BUDGET);
      S_AXI_ARVALID = 1'b0;
      if (!hs) rd_timeout = 1;
      rd_ar_drop = S_AXI_ARREADY;
      while (!done && !rd_timeout) begin
         if (prev_hold && (!S_AXI_RVALID || S_AXI_RDATA !== p_data ||
                           S_AXI_RRESP !== p_resp || S_AXI_RLAST !== p_last))
            rd_unstable++;
         if (S_AXI_RVALID && !seen) begin
            rd_lat = lat; seen = 1;
         end else if (!seen) begin
            lat++;
         end
         rr = mode ? ((cyc % 2) == 0) : 1'b1;
         rd_stall = mode && ((cyc % 5) == 3);
         S_AXI_RREADY = rr;
         if (abort_after != 0 && rd_n == abort_after && S_AXI_RVALID) begin
            rd_aborted = 1;
            break;
         end
         if (S_AXI_RVALID && rr && rd_n < 32) begin
            rd_data[rd_n] = S_AXI_RDATA; rd_resp[rd_n] = S_AXI_RRESP; rd_lastv[rd_n] = S_AXI_RLAST;
            rd_resp_or |= S_AXI_RRESP;
            if (S_AXI_RLAST) begin
               rd_last_cnt++; done = 1;
            end
            rd_n++;
         end
         prev_hold = S_AXI_RVALID && !rr;
         p_data = S_AXI_RDATA; p_resp = S_AXI_RRESP; p_last = S_AXI_RLAST;
         @(posedge fclk); #1; cyc++;
         if (cyc >= BUDGET) rd_timeout = 1;
      end
      if (!rd_aborted) S_AXI_RREADY = 1'b0;
      rd_stall = 1'b0;
      rd_ar_after = S_AXI_ARREADY;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0; S_AXI_ARBURST = '0; S_AXI_ARVALID = 0;
      S_AXI_RREADY = 0;
      S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0; S_AXI_AWBURST = '0; S_AXI_AWVALID = 0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
      rd_stall = 0; wr_stall = 0;
      for (int i = 0; i < 32; i++) wd[i] = '0;

      repeat (3) @(posedge fclk);
      #1;
      check("rst_arready", S_AXI_ARREADY, 0);
      check("rst_awready", S_AXI_AWREADY, 0);
      check("rst_wready",  S_AXI_WREADY, 0);
      check("rst_rvalid",  S_AXI_RVALID, 0);
      check("rst_rlast",   S_AXI_RLAST, 0);
      check("rst_bvalid",  S_AXI_BVALID, 0);
      check("rst_rresp",   S_AXI_RRESP, 0);
      check("rst_bresp",   S_AXI_BRESP, 0);
      check("rst_rdata",   S_AXI_RDATA, 0);
      check("rst_rd_fsm",  rd_fsm, 0);
      check("rst_wr_fsm",  wr_fsm, 0);
      rst_n = 1'b1;
      @(posedge fclk); #1;
      check("arready_rise", S_AXI_ARREADY, 1);
      check("awready_rise", S_AXI_AWREADY, 1);

      // 16-beat write of 0..15 at 0x100, then full-rate read back
      for (int i = 0; i < 16; i++) wd[i] = 64'(i);
      wr_burst(32'h100, 4'd15, 16, 8'hFF, 0);
      check("w1_timeout", wr_timeout, 0);
      check("w1_bresp", wr_bresp, 2'b00);
      check("w1_bvalid_next", wr_bvalid_next, 1);
      check("w1_awready_after", wr_awready_after, 1);
      rd_burst(32'h100, 4'd15, 3'b011, 0, 0);
      check("r1_timeout", rd_timeout, 0);
      check("r1_beats", rd_n, 16);
      check("r1_latency", rd_lat, 2);
      check("r1_arready_drop", rd_ar_drop, 0);
      check("r1_arready_after", rd_ar_after, 1);
      check("r1_resp", rd_resp_or, 2'b00);
      check("r1_last_cnt", rd_last_cnt, 1);
      check("r1_last_pos", rd_lastv[15], 1);
      expect_seq("r1_data", 64'd0, 16);

      // same read under RREADY toggling and rd_stall pulses
      rd_burst(32'h100, 4'd15, 3'b011, 1, 0);
      check("r2_timeout", rd_timeout, 0);
      check("r2_beats", rd_n, 16);
      check("r2_stable", rd_unstable, 0);
      check("r2_last_cnt", rd_last_cnt, 1);
      expect_seq("r2_data", 64'd0, 16);

      // bad ARSIZE: data still returned, every beat SLVERR
      rd_burst(32'h100, 4'd3, 3'b010, 0, 0);
      check("r3_beats", rd_n, 4);
      for (int i = 0; i < 4; i++) check("r3_slverr", rd_resp[i], 2'b10);
      check("r3_last_pos", rd_lastv[3], 1);
      expect_seq("r3_data", 64'd0, 4);

      // WLAST on beat 2 of a 4-beat burst
      wd[0] = 64'h1111; wd[1] = 64'h2222;
      wr_burst(32'h400, 4'd3, 2, 8'hFF, 0);
      check("w4_timeout", wr_timeout, 0);
      check("w4_bresp", wr_bresp, 2'b10);

      // byte strobes: low half cleared, high half kept
      wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      wr_burst(32'h800, 4'd0, 1, 8'hFF, 0);
      wd[0] = 64'h0;
      wr_burst(32'h800, 4'd0, 1, 8'h0F, 0);
      check("w5_bresp", wr_bresp, 2'b00);
      rd_burst(32'h800, 4'd0, 3'b011, 0, 0);
      check("r5_beats", rd_n, 1);
      check("r5_strb_data", rd_data[0], 64'hFFFF_FFFF_0000_0000);

      // index wrap: 1022, 1023, 0, 1
      for (int i = 0; i < 4; i++) wd[i] = 64'hA0 + 64'(i);
      wr_burst(32'h1FF0, 4'd3, 4, 8'hFF, 0);
      check("w6_bresp", wr_bresp, 2'b00);
      rd_burst(32'h1FF0, 4'd3, 3'b011, 0, 0);
      expect_seq("r6_wrap_data", 64'hA0, 4);
      rd_burst(32'h0, 4'd1, 3'b011, 0, 0);
      expect_seq("r6_low_words", 64'hA2, 2);

      // concurrent 16-beat write (with wr_stall) and read
      for (int i = 0; i < 16; i++) wd[i] = 64'h5500 + 64'(i);
      fork
         wr_burst(32'h1000, 4'd15, 16, 8'hFF, 1);
         rd_burst(32'h100, 4'd15, 3'b011, 0, 0);
      join
      check("c7_wr_timeout", wr_timeout, 0);
      check("c7_bresp", wr_bresp, 2'b00);
      check("c7_rd_beats", rd_n, 16);
      expect_seq("c7_rd_data", 64'd0, 16);
      rd_burst(32'h1000, 4'd15, 3'b011, 0, 0);
      expect_seq("c7_wr_data", 64'h5500, 16);

      // reset while beat 5 of a 16-beat read is presented
      rd_burst(32'h100, 4'd15, 3'b011, 0, 4);
      check("r8_reached_beat5", rd_aborted, 1);
      check("r8_beat5_data", S_AXI_RDATA, 64'd4);
      S_AXI_RREADY = 1'b0;
      rst_n = 1'b0;
      #1;
      check("r8_rvalid_rst", S_AXI_RVALID, 0);
      check("r8_rd_fsm_rst", rd_fsm, 0);
      @(posedge fclk); #1;
      rst_n = 1'b1;
      @(posedge fclk); #1;
      check("r8_arready_after", S_AXI_ARREADY, 1);
      rd_burst(32'h100, 4'd3, 3'b011, 0, 0);
      check("r8_new_beats", rd_n, 4);
      check("r8_new_resp", rd_resp_or, 2'b00);
      expect_seq("r8_new_data", 64'd0, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
